// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter/controller.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int   LAT_MAX  = 4;
  localparam logic CPU_PORT = 1'b0;
  localparam logic LDR_PORT = 1'b1;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/arb_pick.sv
// 2-way winner select. On a tie the index not equal to 'last' wins; a constant
// last = LDR_PORT degenerates to fixed CPU priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant,
  output logic       any
);
  assign any   = |valid;
  assign grant = (&valid) ? ~last : valid[LDR_PORT];
endmodule

// File: rtl/mem_arb_ctrl.sv
// Two-requester arbiter in front of a single-ported memory, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin ties; default build gives the CPU port priority.
module mem_arb_ctrl
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int LAT    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata
);
  localparam logic [2:0] LAT_LD = 3'((LAT > LAT_MAX) ? LAT_MAX : ((LAT < 1) ? 1 : LAT));

  state_t              state, state_nxt;
  logic                win, any, accept, last;
  logic                cmd_idx, cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [2:0]          cnt;

  arb_pick u_pick (.valid(req_valid), .last(last), .grant(win), .any(any));

`ifdef MEM_ARB_RR_EN
  // Pointer holds the last granted index; reset value steers the first tie to CPU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last <= LDR_PORT;
    else if (accept) last <= win;
  end
`else
  assign last = LDR_PORT;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: if (any) begin
        accept    = 1'b1;
        req_ready = port_onehot(win);
        state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = cmd_we;
        mem_addr  = cmd_addr;
        mem_wdata = cmd_wdata;
        state_nxt = cmd_we ? RESP : WAIT;
      end
      WAIT: if (cnt == 3'd1) state_nxt = RESP;
      RESP: begin
        rsp_valid = port_onehot(cmd_idx);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter reaches 1 in the cycle LAT after mem_en; read data is captured then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_idx   <= CPU_PORT;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        cmd_idx   <= win;
        cmd_we    <= req_we[win];
        cmd_addr  <= req_addr[win];
        cmd_wdata <= req_wdata[win];
      end
      if (state == ISSUE) cnt <= LAT_LD;
      else if (state == WAIT) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) rsp_rdata <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench: LAT=2 instance for most scenarios, LAT=4 instance for the long-read hold case.
module tb_mem_arb_ctrl;
  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid, req_ready, req_we, rsp_valid;
  logic [1:0][63:0]  req_addr, req_wdata;
  logic [63:0]       rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic              mem_en, mem_we;

  logic [1:0]        v4, r4, rsp4;
  logic [63:0]       rdata4, maddr4, mwd4, mrd4;
  logic              mem_en4, mem_we4;

  logic [1:0]        dly  = '0;
  logic [3:0]        dly4 = '0;
  logic [63:0]       mdata;
  logic [1:0]        exp_g [4];
  int                checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_arb_ctrl #(.DATA_W(64), .ADDR_W(64), .LAT(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  mem_arb_ctrl #(.DATA_W(64), .ADDR_W(64), .LAT(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(v4), .req_ready(r4), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp4), .rsp_rdata(rdata4),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(maddr4), .mem_wdata(mwd4),
    .mem_rdata(mrd4));

  // Memory model: read data is valid only exactly LAT cycles after a read mem_en.
  always @(posedge clk) begin
    dly  <= {dly[0], mem_en & ~mem_we};
    dly4 <= {dly4[2:0], mem_en4 & ~mem_we4};
  end
  assign mem_rdata = dly[1]  ? mdata : 64'hBAD0_BAD0_BAD0_BAD0;
  assign mrd4      = dly4[3] ? mdata : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
    rst = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    v4 = '0; mdata = '0;
    repeat (2) tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst = 1'b1;
    tick();

    // CPU read 0x40, LAT=2
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 64'h40; mdata = 64'hDEAD_BEEF; #1;
    chk("rd_ready", req_ready, 2'b01);
    tick(); req_valid = '0; #1;
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 64'h40);
    chk("rd_busy_ready", req_ready, 0);
    tick(); #1;
    chk("rd_t2_mem_en", mem_en, 0);
    chk("rd_t2_rsp", rsp_valid, 0);
    tick(); #1;
    chk("rd_t3_rsp", rsp_valid, 0);
    tick(); #1;
    chk("rd_t4_rsp", rsp_valid, 2'b01);
    chk("rd_t4_rdata", rsp_rdata, 64'hDEAD_BEEF);
    tick(); #1;
    chk("rd_t5_rsp", rsp_valid, 0);
    chk("rd_t5_rdata_hold", rsp_rdata, 64'hDEAD_BEEF);

    // Loader write 0x80 <- 0x1234
    req_valid = 2'b10; req_we = 2'b10; req_addr[1] = 64'h80; req_wdata[1] = 64'h1234; #1;
    chk("wr_ready", req_ready, 2'b10);
    tick(); req_valid = '0; #1;
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 64'h80);
    chk("wr_mem_wdata", mem_wdata, 64'h1234);
    tick(); #1;
    chk("wr_rsp", rsp_valid, 2'b10);
    chk("wr_rdata_unchanged", rsp_rdata, 64'hDEAD_BEEF);
    tick(); #1;
    chk("wr_rsp_done", rsp_valid, 0);
    chk("wr_mem_en_done", mem_en, 0);

    // Back-to-back CPU writes: mem_en every third cycle
    req_valid = 2'b01; req_we = 2'b01; req_wdata[0] = 64'h55;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("b2b_mem_en", mem_en, (i % 3 == 1) ? 64'd1 : 64'd0);
      chk("b2b_ready", req_ready, (i % 3 == 0) ? 64'd1 : 64'd0);
      tick();
    end
    req_valid = '0;

    // Both requesters continuously valid, fresh from reset
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    req_valid = 2'b11; req_we = 2'b11;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (i % 3 == 0) chk("arb_grant", req_ready, exp_g[i / 3]);
      else            chk("arb_no_grant", req_ready, 0);
      if (i % 3 == 2) chk("arb_rsp", rsp_valid, exp_g[i / 3]);
      else            chk("arb_no_rsp", rsp_valid, 0);
      tick();
    end
    req_valid = '0;

    // Reset while waiting on read data
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 64'h100; mdata = 64'h7777; #1;
    chk("abort_ready", req_ready, 2'b01);
    tick(); req_valid = '0; #1;
    chk("abort_mem_en", mem_en, 1);
    tick();
    rst = 1'b0; #1;
    chk("abort_rsp", rsp_valid, 0);
    chk("abort_mem_en_off", mem_en, 0);
    chk("abort_rdata_clr", rsp_rdata, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk("abort_no_rsp", rsp_valid, 0);
      chk("abort_no_mem_en", mem_en, 0);
    end
    rst = 1'b1;
    req_valid = 2'b10; req_we = 2'b00; req_addr[1] = 64'h200; mdata = 64'hCAFE; #1;
    chk("post_rst_ready", req_ready, 2'b10);
    tick(); req_valid = '0; #1;
    chk("post_rst_mem_en", mem_en, 1);
    chk("post_rst_addr", mem_addr, 64'h200);
    tick(); tick(); #1;
    chk("post_rst_no_rsp", rsp_valid, 0);
    tick(); #1;
    chk("post_rst_rsp", rsp_valid, 2'b10);
    chk("post_rst_rdata", rsp_rdata, 64'hCAFE);
    tick();

    // LAT=4 read with loader held valid
    v4 = 2'b01; req_we = 2'b00; req_addr[0] = 64'h300; mdata = 64'h1111; #1;
    chk("l4_ready", r4, 2'b01);
    tick(); v4 = 2'b10; req_addr[1] = 64'h400; #1;
    chk("l4_mem_en", mem_en4, 1);
    chk("l4_mem_addr", maddr4, 64'h300);
    chk("l4_hold_ready", r4, 0);
    for (int i = 2; i <= 5; i++) begin
      tick(); #1;
      chk("l4_wait_ready", r4, 0);
      chk("l4_wait_rsp", rsp4, 0);
    end
    tick(); #1;
    chk("l4_rsp", rsp4, 2'b01);
    chk("l4_rdata", rdata4, 64'h1111);
    chk("l4_resp_ready", r4, 0);
    tick(); mdata = 64'h2222; #1;
    chk("l4_ldr_ready", r4, 2'b10);
    tick(); v4 = '0; #1;
    chk("l4_ldr_mem_en", mem_en4, 1);
    chk("l4_ldr_addr", maddr4, 64'h400);
    repeat (5) tick();
    #1;
    chk("l4_ldr_rsp", rsp4, 2'b10);
    chk("l4_ldr_rdata", rdata4, 64'h2222);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
